// File: rtl/shift_deserializer.sv
// shift_deserializer: idle-high, LSB-first asynchronous serial receiver.
// Frame: start bit, w_data data bits, optional even-parity bit, stop bit.
// The received word is presented on out_data with a valid/ready handshake.
// Optional feature macro: SHIFT_DESERIALIZER_PARITY_EN (adds the PARITY
// state and the parity_err output).
module shift_deserializer #(
  parameter int w_data     = 8,
  parameter int bit_period = 434
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              serial_in,
  output logic [w_data-1:0] out_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic              busy,
  output logic              frame_err,
  output logic              overrun
`ifdef SHIFT_DESERIALIZER_PARITY_EN
  ,
  output logic              parity_err
`endif
);

  localparam int TW    = $clog2(bit_period);
  localparam int IDX_W = (w_data > 1) ? $clog2(w_data) : 1;

  localparam logic [TW-1:0]    HALF_LOAD = TW'(bit_period / 2 - 1);
  localparam logic [TW-1:0]    FULL_LOAD = TW'(bit_period - 1);
  localparam logic [TW-1:0]    TIMER_ONE = TW'(1);
  localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(w_data - 1);
  localparam logic [IDX_W-1:0] IDX_ONE   = IDX_W'(1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    PARITY,
`endif
    STOP,
    WAIT_HIGH
  } state_t;

  state_t state_reg, state_next;

  logic              sync_reg;
  logic              rx_s;
  logic [TW-1:0]     timer_reg;
  logic              expire;
  logic [IDX_W-1:0]  bit_idx_reg;
  logic [w_data-1:0] shift_reg;
  logic [w_data:0]   shift_cat;

  logic              timer_load;
  logic [TW-1:0]     timer_val;
  logic              shift_en;
  logic              idx_clear;
  logic              idx_inc;
  logic              stop_ok;
  logic              stop_bad;
  logic              commit;

  assign expire    = (timer_reg == '0);
  assign busy      = (state_reg != IDLE);
  assign shift_cat = {rx_s, shift_reg};

  // Two-flop synchronizer for the asynchronous line; idle level is high.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      sync_reg <= 1'b1;
      rx_s     <= 1'b1;
    end else begin
      sync_reg <= serial_in;
      rx_s     <= sync_reg;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg <= IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

`ifdef SHIFT_DESERIALIZER_PARITY_EN
  logic par_check;
  logic par_bad_now;
  logic par_bad_reg;

  assign par_bad_now = (^shift_reg) ^ rx_s;
`endif

  // Next-state and per-cycle control decode; every sample happens on expire.
  always_comb begin
    state_next = state_reg;
    timer_load = 1'b0;
    timer_val  = FULL_LOAD;
    shift_en   = 1'b0;
    idx_clear  = 1'b0;
    idx_inc    = 1'b0;
    stop_ok    = 1'b0;
    stop_bad   = 1'b0;
`ifdef SHIFT_DESERIALIZER_PARITY_EN
    par_check  = 1'b0;
`endif
    case (state_reg)
      IDLE: begin
        if (!rx_s) begin
          timer_load = 1'b1;
          timer_val  = HALF_LOAD;
          state_next = START;
        end
      end
      START: begin
        if (expire) begin
          if (!rx_s) begin
            timer_load = 1'b1;
            idx_clear  = 1'b1;
            state_next = DATA;
          end else begin
            // Line went back high before mid start bit: treat as a glitch.
            state_next = IDLE;
          end
        end
      end
      DATA: begin
        if (expire) begin
          shift_en   = 1'b1;
          timer_load = 1'b1;
          if (bit_idx_reg == LAST_IDX) begin
`ifdef SHIFT_DESERIALIZER_PARITY_EN
            state_next = PARITY;
`else
            state_next = STOP;
`endif
          end else begin
            idx_inc = 1'b1;
          end
        end
      end
`ifdef SHIFT_DESERIALIZER_PARITY_EN
      PARITY: begin
        if (expire) begin
          par_check  = 1'b1;
          timer_load = 1'b1;
          state_next = STOP;
        end
      end
`endif
      STOP: begin
        if (expire) begin
          if (rx_s) begin
            stop_ok    = 1'b1;
            state_next = IDLE;
          end else begin
            stop_bad   = 1'b1;
            state_next = WAIT_HIGH;
          end
        end
      end
      WAIT_HIGH: begin
        // A line held low after a bad stop bit must not look like a new start.
        if (rx_s) begin
          state_next = IDLE;
        end
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // Bit timer: reload on request, otherwise count down and rest at zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      timer_reg <= '0;
    end else if (timer_load) begin
      timer_reg <= timer_val;
    end else if (!expire) begin
      timer_reg <= timer_reg - TIMER_ONE;
    end
  end

  // Data bit index and right-shifting capture register (LSB arrives first).
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bit_idx_reg <= '0;
      shift_reg   <= '0;
    end else begin
      if (idx_clear) begin
        bit_idx_reg <= '0;
      end else if (idx_inc) begin
        bit_idx_reg <= bit_idx_reg + IDX_ONE;
      end
      if (shift_en) begin
        shift_reg <= shift_cat[w_data:1];
      end
    end
  end

`ifdef SHIFT_DESERIALIZER_PARITY_EN
  // Parity verdict is held until the stop check decides whether to commit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      par_bad_reg <= 1'b0;
      parity_err  <= 1'b0;
    end else begin
      parity_err <= par_check & par_bad_now;
      if (par_check) begin
        par_bad_reg <= par_bad_now;
      end
    end
  end

  assign commit = stop_ok & ~par_bad_reg;
`else
  assign commit = stop_ok;
`endif

  // Output buffer: commit/accept arbitration plus one-cycle error flags.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      out_data  <= '0;
      out_valid <= 1'b0;
      frame_err <= 1'b0;
      overrun   <= 1'b0;
    end else begin
      frame_err <= stop_bad;
      overrun   <= 1'b0;
      if (commit) begin
        if (!out_valid || out_ready) begin
          out_data  <= shift_reg;
          out_valid <= 1'b1;
        end else begin
          // Buffer still owned by the consumer: keep the old word.
          overrun <= 1'b1;
        end
      end else if (out_valid && out_ready) begin
        out_valid <= 1'b0;
      end
    end
  end

endmodule
